// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registers one ALU command, holds its operands stable for
// SETTLE_CYCLES clocks, then captures the ALU outputs and presents them
// downstream with a valid/ready handshake.
// Optional feature: define ALU_ISSUE_STATS_EN to enable the ops_done counter;
// without it ops_done is tied to zero.
module alu_issue_stage #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_cmd,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_cmd,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_carryout,
  output logic        out_zero,
  output logic        out_overflow,
  output logic [2:0]  out_cmd,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       arith_cmd;

  // Only ADD (0) and SUB (1) produce meaningful carry/overflow flags.
  assign arith_cmd = (alu_cmd[2:1] == 2'b00);

  // Issue FSM: accept in IDLE, wait out the settle time, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      in_ready     <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cmd      <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_cmd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            alu_a    <= in_a;
            alu_b    <= in_b;
            alu_cmd  <= in_cmd;
            cnt      <= 4'(SETTLE_CYCLES);
            in_ready <= 1'b0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            out_result   <= alu_result;
            out_zero     <= alu_zero;
            out_carryout <= arith_cmd ? alu_carryout : 1'b0;
            out_overflow <= arith_cmd ? alu_overflow : 1'b0;
            out_cmd      <= alu_cmd;
            out_valid    <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          // in_ready rises only after this edge, so no command can be
          // accepted in the same cycle the result is consumed.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  // Count consumed results, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_done <= '0;
    end else if (out_valid && out_ready && (ops_done != '1)) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`else
  assign ops_done = '0;
`endif

endmodule
